// File: rtl/ascon_round_engine.sv
// Iterative Ascon permutation engine: applies p^n (pC, pS, pL) to a 320-bit
// state, RPC rounds per clock, with valid/ready handshakes on both sides.
module ascon_round_engine #(
  parameter int RPC        = 1,
  parameter int MAX_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [319:0] in_state,
  input  logic [3:0]   in_rounds,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] R_MAX  = 4'(MAX_ROUNDS);

  logic [1:0]   fsm;
  logic [319:0] state_q;
  logic [3:0]   rnd_q;
  logic [3:0]   n_req;
  logic [319:0] one_round;
  logic [319:0] two_round;
  logic [319:0] run_state;
  logic [3:0]   run_rnd;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned k);
    return (v >> k) | (v << (64 - k));
  endfunction

  function automatic logic [319:0] round_fn(input logic [319:0] s, input logic [3:0] i);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    // Round constant: high nibble counts down from F while the low nibble counts up.
    x2 ^= {56'd0, 4'hF - i, i};
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    x0 ^= ror(x0, 19) ^ ror(x0, 28);
    x1 ^= ror(x1, 61) ^ ror(x1, 39);
    x2 ^= ror(x2, 1)  ^ ror(x2, 6);
    x3 ^= ror(x3, 10) ^ ror(x3, 17);
    x4 ^= ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  always_comb n_req = (in_rounds > R_MAX) ? R_MAX : in_rounds;

  assign one_round = round_fn(state_q, rnd_q);
  assign two_round = round_fn(one_round, rnd_q + 4'd1);

  // The last cycle of an odd-length run on a two-round datapath applies one round.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    run_state = one_round;
    run_rnd   = rnd_q + 4'd1;
    if (RPC == 2 && (R_MAX - rnd_q) >= 4'd2) begin
      run_state = two_round;
      run_rnd   = rnd_q + 4'd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      fsm     <= S_IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      case (fsm)
        S_IDLE: if (in_valid) begin
          state_q <= in_state;
          rnd_q   <= R_MAX - n_req;
          fsm     <= (n_req == 4'd0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          state_q <= run_state;
          rnd_q   <= run_rnd;
          if (run_rnd == R_MAX) fsm <= S_DONE;
        end
        S_DONE: if (out_ready) fsm <= S_IDLE;
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm == S_IDLE);
  assign busy      = (fsm == S_RUN);
  assign out_valid = (fsm == S_DONE);
  assign out_state = state_q;

endmodule

// File: tb/tb_ascon_round_engine.sv
// Scoreboard bench for ascon_round_engine: RPC=1 and RPC=2 instances share
// stimulus and are checked against a table-driven bit-sliced Ascon model.
module tb_ascon_round_engine;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [319:0] in_state = '0;
  logic [3:0]   in_rounds = '0;
  logic         out_ready = 1'b1;
  logic         in_ready1, in_ready2, out_valid1, out_valid2, busy1, busy2;
  logic [319:0] out_state1, out_state2;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [319:0] exp;
    int           lat;
    int           acc;
  } txn_t;

  txn_t q1[$];
  txn_t q2[$];
  bit   prev1 = 1'b0;
  bit   prev2 = 1'b0;

  logic [4:0] sbox [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  int rot_a [5] = '{19, 61, 1, 10, 7};
  int rot_b [5] = '{28, 39, 6, 17, 41};

  ascon_round_engine #(.RPC(1), .MAX_ROUNDS(12)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid1),
    .out_ready(out_ready), .out_state(out_state1), .busy(busy1));

  ascon_round_engine #(.RPC(2), .MAX_ROUNDS(12)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_state(in_state), .in_rounds(in_rounds), .out_valid(out_valid2),
    .out_ready(out_ready), .out_state(out_state2), .busy(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] v, input int k);
    return (v >> k) | (v << (64 - k));
  endfunction

  // Reference permutation: S-box applied column by column through the lookup table.
  function automatic logic [319:0] ref_perm(input logic [319:0] st, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    for (int k = 0; k < 5; k++) x[k] = st[319 - 64*k -: 64];
    for (int i = 12 - n; i < 12; i++) begin
      x[2] ^= 64'((15 - i) * 16 + i);
      for (int b = 0; b < 64; b++) begin
        col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
        for (int k = 0; k < 5; k++) y[k][b] = sbox[col][4 - k];
      end
      for (int k = 0; k < 5; k++) x[k] = y[k] ^ rotr(y[k], rot_a[k]) ^ rotr(y[k], rot_b[k]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic int lat(input int n, input int rpc);
    return (n == 0) ? 1 : 1 + (n + rpc - 1) / rpc;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int k = 0; k < 10; k++) s[k*32 +: 32] = $urandom();
    return s;
  endfunction

  // Monitors: compare once per transaction, on the rising edge of out_valid.
  always @(negedge clk) begin
    if (rst) prev1 <= 1'b0;
    else begin
      if (out_valid1 && !prev1) begin
        check("dut1_expected_pending", 320'(q1.size() != 0), 320'(1));
        if (q1.size() != 0) begin
          check("dut1_state", out_state1, q1[0].exp);
          check("dut1_latency", 320'(cyc - q1[0].acc + 1), 320'(q1[0].lat));
          q1.delete(0);
        end
      end
      prev1 <= out_valid1;
    end
  end

  always @(negedge clk) begin
    if (rst) prev2 <= 1'b0;
    else begin
      if (out_valid2 && !prev2) begin
        check("dut2_expected_pending", 320'(q2.size() != 0), 320'(1));
        if (q2.size() != 0) begin
          check("dut2_state", out_state2, q2[0].exp);
          check("dut2_latency", 320'(cyc - q2[0].acc + 1), 320'(q2[0].lat));
          q2.delete(0);
        end
      end
      prev2 <= out_valid2;
    end
  end

  task automatic send(input logic [319:0] st, input logic [3:0] rnds, input logic [319:0] exp);
    int n;
    bit ok;
    n  = (rnds > 4'd12) ? 12 : int'(rnds);
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready1 && in_ready2;
    end
    check("accept_ready", 320'(ok), 320'(1));
    if (!ok) return;
    in_valid  = 1'b1;
    in_state  = st;
    in_rounds = rnds;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    q1.push_back('{exp, lat(n, 1), cyc});
    q2.push_back('{exp, lat(n, 2), cyc});
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 100 && !empty; k++) begin
      @(negedge clk);
      empty = (q1.size() == 0) && (q2.size() == 0);
    end
    check("drain", 320'(empty), 320'(1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready1"}, 320'(in_ready1), 320'(1));
    check({tag, "_in_ready2"}, 320'(in_ready2), 320'(1));
    check({tag, "_out_valid1"}, 320'(out_valid1), 320'(0));
    check({tag, "_out_valid2"}, 320'(out_valid2), 320'(0));
    check({tag, "_busy1"}, 320'(busy1), 320'(0));
    check({tag, "_busy2"}, 320'(busy2), 320'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [319:0] st;
    logic [319:0] exp;
    logic [3:0]   rtab [3];
    bit           done_seen;
    rtab = '{4'd6, 4'd8, 4'd12};

    #1 rst = 1'b1;
    #1 check_idle("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Known-answer vector: zero state, one round.
    send('0, 4'd1, {64'h000964B00000004B, 64'h0000000096000213,
                    64'h53FFFFFFFFFFFF90, 64'h12E580000000004B, 64'h0});
    drain();

    // Pass-through.
    for (int k = 0; k < 3; k++) begin
      st = rand_state();
      send(st, 4'd0, st);
      drain();
    end

    // Random states at the standard round counts.
    for (int k = 0; k < 100; k++) begin
      st = rand_state();
      for (int j = 0; j < 3; j++) begin
        send(st, rtab[j], ref_perm(st, int'(rtab[j])));
        drain();
      end
    end

    // Clamping and odd round counts.
    st = rand_state();
    exp = ref_perm(st, 12);
    send(st, 4'd15, exp);
    drain();
    send(st, 4'd12, exp);
    drain();
    for (int r = 1; r < 16; r += 2) begin
      st = rand_state();
      send(st, 4'(r), ref_perm(st, (r > 12) ? 12 : r));
      drain();
    end

    // Backpressure, with requests offered while both engines are occupied.
    st  = rand_state();
    exp = ref_perm(st, 12);
    out_ready = 1'b0;
    send(st, 4'd12, exp);
    done_seen = 1'b0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_state  = rand_state();
      in_rounds = 4'd3;
      check("occupied_in_ready1", 320'(in_ready1), 320'(0));
      check("occupied_in_ready2", 320'(in_ready2), 320'(0));
      done_seen = out_valid1 && out_valid2;
    end
    check("backpressure_done", 320'(done_seen), 320'(1));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_out_valid1", 320'(out_valid1), 320'(1));
      check("hold_out_valid2", 320'(out_valid2), 320'(1));
      check("hold_out_state1", out_state1, exp);
      check("hold_out_state2", out_state2, exp);
      check("hold_in_ready1", 320'(in_ready1), 320'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("released");
    drain();
    st = rand_state();
    send(st, 4'd8, ref_perm(st, 8));
    drain();

    // Reset in the fifth RUN cycle discards the in-flight job.
    st = rand_state();
    send(st, 4'd12, ref_perm(st, 12));
    repeat (4) @(posedge clk);
    #2;
    check("pre_reset_busy1", 320'(busy1), 320'(1));
    check("pre_reset_busy2", 320'(busy2), 320'(1));
    rst = 1'b1;
    #1;
    check_idle("mid_run_reset");
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst = 1'b0;
    st = rand_state();
    send(st, 4'd12, ref_perm(st, 12));
    drain();
    st = rand_state();
    send(st, 4'd7, ref_perm(st, 7));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
